vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing: counters plus sync/blank decode, all registered from next-state counters.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       valid,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state_q, state_d;
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       valid_q, valid_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   // Decode uses the next-state counters so outputs land on the same edge as the counters.
   always_comb begin
      state_d = RUN;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (state_q == IDLE) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
         h_cnt_d = h_cnt_q + 10'd1;
      end
      valid_d       = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
      hsync_d       = ((h_cnt_d >= HS_BEG) && (h_cnt_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = ((v_cnt_d >= VS_BEG) && (v_cnt_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_d == 10'd0);
      frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         valid_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         valid_q       <= valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign valid       = valid_q;
   assign h_cnt       = h_cnt_q;
   assign v_cnt       = v_cnt_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Counts only real wraps out of the last pixel; the IDLE->RUN edge is not a wrap.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if ((state_q == RUN) && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST))
         frame_cnt_d = frame_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
